// File: rtl/tail_light_decoder.sv
// Receive-side monitor for the six-lamp tail-light bus: decodes mode/phase, flags illegal sequences, counts sweeps.
// Optional macro TLD_ERR_CNT_EN adds err_cnt, a saturating count of entries into the error state.
module tail_light_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             LA,
  input  logic             LB,
  input  logic             LC,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  input  logic             clr_err,
  output logic [1:0]       mode,
  output logic [1:0]       phase,
  output logic             brake_det,
  output logic             hazard_det,
  output logic             sweep_done,
  output logic [CNT_W-1:0] sweep_cnt,
  output logic             sync_lost,
`ifdef TLD_ERR_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             seq_err
);

  localparam int unsigned PAT_W = 6;

  localparam logic [PAT_W-1:0] P_OFF = 6'b000000;
  localparam logic [PAT_W-1:0] P_L1  = 6'b100000;
  localparam logic [PAT_W-1:0] P_L2  = 6'b110000;
  localparam logic [PAT_W-1:0] P_L3  = 6'b111000;
  localparam logic [PAT_W-1:0] P_R1  = 6'b000100;
  localparam logic [PAT_W-1:0] P_R2  = 6'b000110;
  localparam logic [PAT_W-1:0] P_R3  = 6'b000111;
  localparam logic [PAT_W-1:0] P_ALL = 6'b111111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_L3,
    S_R1,
    S_R2,
    S_R3,
    S_ALL1,
    S_ALLN,
    S_ERR
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [PAT_W-1:0]   pat;
  logic               err_entry;
  logic [1:0]         mode_nx;
  logic [1:0]         phase_nx;
  logic               brake_nx;
  logic               hazard_nx;
  logic               sweep_done_nx;
  logic               sync_nx;
  logic               seq_err_nx;
  logic [CNT_W-1:0]   sweep_cnt_nx;
`ifdef TLD_ERR_CNT_EN
  logic [CNT_W-1:0]   err_cnt_nx;
`endif

  assign pat = {LA, LB, LC, RA, RB, RC};

  // Next state, then every registered output derived from the next state and transition
  always_comb begin
    state_nx      = S_ERR;
    err_entry     = 1'b0;
    mode_nx       = 2'b00;
    phase_nx      = 2'd0;
    brake_nx      = 1'b0;
    hazard_nx     = 1'b0;
    sweep_done_nx = 1'b0;
    sync_nx       = 1'b0;
    seq_err_nx    = seq_err;
    sweep_cnt_nx  = sweep_cnt;
`ifdef TLD_ERR_CNT_EN
    err_cnt_nx    = err_cnt;
`endif

    case (state)
      S_IDLE: begin
        case (pat)
          P_OFF:   state_nx = S_IDLE;
          P_L1:    state_nx = S_L1;
          P_R1:    state_nx = S_R1;
          P_ALL:   state_nx = S_ALL1;
          default: state_nx = S_ERR;
        endcase
      end
      S_L1: begin
        if (pat == P_L2)       state_nx = S_L2;
        else if (pat == P_OFF) state_nx = S_IDLE;
      end
      S_L2: begin
        if (pat == P_L3)       state_nx = S_L3;
        else if (pat == P_OFF) state_nx = S_IDLE;
      end
      S_R1: begin
        if (pat == P_R2)       state_nx = S_R2;
        else if (pat == P_OFF) state_nx = S_IDLE;
      end
      S_R2: begin
        if (pat == P_R3)       state_nx = S_R3;
        else if (pat == P_OFF) state_nx = S_IDLE;
      end
      S_L3, S_R3: begin
        if (pat == P_OFF)      state_nx = S_IDLE;
      end
      S_ALL1, S_ALLN: begin
        if (pat == P_ALL)      state_nx = S_ALLN;
        else if (pat == P_OFF) state_nx = S_IDLE;
      end
      S_ERR: begin
        state_nx = (pat == P_OFF) ? S_IDLE : S_ERR;
      end
      default: state_nx = S_ERR;
    endcase

    err_entry     = (state_nx == S_ERR) && (state != S_ERR);
    sweep_done_nx = ((state == S_L3) || (state == S_R3)) && (state_nx == S_IDLE);
    hazard_nx     = (state == S_ALL1) && (state_nx == S_IDLE);
    brake_nx      = (state_nx == S_ALLN);
    sync_nx       = (state_nx == S_ERR);

    case (state_nx)
      S_L1:           begin mode_nx = 2'b01; phase_nx = 2'd1; end
      S_L2:           begin mode_nx = 2'b01; phase_nx = 2'd2; end
      S_L3:           begin mode_nx = 2'b01; phase_nx = 2'd3; end
      S_R1:           begin mode_nx = 2'b10; phase_nx = 2'd1; end
      S_R2:           begin mode_nx = 2'b10; phase_nx = 2'd2; end
      S_R3:           begin mode_nx = 2'b10; phase_nx = 2'd3; end
      S_ALL1, S_ALLN: begin mode_nx = 2'b11; phase_nx = 2'd0; end
      default:        begin mode_nx = 2'b00; phase_nx = 2'd0; end
    endcase

    if (sweep_done_nx && (sweep_cnt != CNT_MAX)) begin
      sweep_cnt_nx = sweep_cnt + CNT_W'(1);
    end

    // A new error entry outranks a clear in the same cycle
    if (err_entry)    seq_err_nx = 1'b1;
    else if (clr_err) seq_err_nx = 1'b0;

`ifdef TLD_ERR_CNT_EN
    if (err_entry) begin
      if (clr_err)                 err_cnt_nx = CNT_W'(1);
      else if (err_cnt != CNT_MAX) err_cnt_nx = err_cnt + CNT_W'(1);
    end else if (clr_err) begin
      err_cnt_nx = '0;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      mode       <= 2'b00;
      phase      <= 2'd0;
      brake_det  <= 1'b0;
      hazard_det <= 1'b0;
      sweep_done <= 1'b0;
      sweep_cnt  <= '0;
      sync_lost  <= 1'b0;
      seq_err    <= 1'b0;
`ifdef TLD_ERR_CNT_EN
      err_cnt    <= '0;
`endif
    end else begin
      state      <= state_nx;
      mode       <= mode_nx;
      phase      <= phase_nx;
      brake_det  <= brake_nx;
      hazard_det <= hazard_nx;
      sweep_done <= sweep_done_nx;
      sweep_cnt  <= sweep_cnt_nx;
      sync_lost  <= sync_nx;
      seq_err    <= seq_err_nx;
`ifdef TLD_ERR_CNT_EN
      err_cnt    <= err_cnt_nx;
`endif
    end
  end

endmodule
